percentile_cdf_engine: RTL and testbench

Parametrised successor to the camera-path cumulative-histogram stage. It scans a histogram RAM of NUM_BINS bins and streams the running cumulative sum into a CDF RAM. While scanning it resolves NUM_PCT programmable percentile thresholds, the mode bin and its count, and the saturated pixel total. It sits between the per-frame histogram accumulator and the thresholding/contrast logic, and can optionally zero the source histogram as it reads it so the next frame starts clean.

---
 rtl/percentile_cdf_engine.sv | 224 ++++++++++++++++++++++
 tb/tb_percentile_cdf_engine.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/percentile_cdf_engine.sv
// Histogram-to-CDF scan engine: streams the saturating cumulative sum into a CDF RAM
// and resolves percentile thresholds, the mode bin and the pixel total in the same pass.
module percentile_cdf_engine #(
  parameter int BIN_BITS = 8,
  parameter int COUNT_W  = 20,
  parameter int NUM_PCT  = 3,
  parameter int READ_LAT = 1
) (
  input  logic                        iClk,
  input  logic                        iRst_n,
  input  logic                        iStart,
  input  logic                        iClearSrc,
  input  logic [NUM_PCT*COUNT_W-1:0]  iTargets,
  output logic                        oBusy,
  output logic                        oDone,
  output logic [BIN_BITS-1:0]         oSrcAddr,
  input  logic [COUNT_W-1:0]          iSrcQ,
  output logic [BIN_BITS-1:0]         oSrcWAddr,
  output logic                        oSrcWe,
  output logic [BIN_BITS-1:0]         oCdfAddr,
  output logic [COUNT_W-1:0]          oCdfData,
  output logic                        oCdfWe,
  output logic [NUM_PCT*BIN_BITS-1:0] oThresh,
  output logic [NUM_PCT-1:0]          oThreshValid,
  output logic [COUNT_W-1:0]          oMaxCount,
  output logic [BIN_BITS-1:0]         oMaxBin,
  output logic [COUNT_W-1:0]          oTotal,
  output logic                        oOverflow
);

  localparam int FLUSH_W = $clog2(READ_LAT + 1) + 1;

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

  state_t                         state_q, state_d;
  logic [BIN_BITS-1:0]            addr_q, addr_d;
  logic [FLUSH_W-1:0]             flush_cnt_q, flush_cnt_d;
  logic                           clear_q, clear_d;
  logic [NUM_PCT*COUNT_W-1:0]     tgt_q, tgt_d;
  logic [READ_LAT-1:0]            vld_q, vld_d;
  logic [READ_LAT-1:0][BIN_BITS-1:0] pipe_addr_q, pipe_addr_d;
  logic [COUNT_W-1:0]             cum_q, cum_d;
  logic                           ovf_q, ovf_d;
  logic [NUM_PCT-1:0]             found_q, found_d;
  logic [NUM_PCT*BIN_BITS-1:0]    thr_q, thr_d;
  logic [COUNT_W-1:0]             max_q, max_d;
  logic [BIN_BITS-1:0]            max_bin_q, max_bin_d;
  logic                           cdf_we_q, cdf_we_d;
  logic [BIN_BITS-1:0]            cdf_addr_q, cdf_addr_d;
  logic [COUNT_W-1:0]             cdf_data_q, cdf_data_d;
  logic [NUM_PCT*BIN_BITS-1:0]    thresh_q, thresh_d;
  logic [NUM_PCT-1:0]             thresh_valid_q, thresh_valid_d;
  logic [COUNT_W-1:0]             max_count_q, max_count_d;
  logic [BIN_BITS-1:0]            max_bin_res_q, max_bin_res_d;
  logic [COUNT_W-1:0]             total_q, total_d;
  logic                           overflow_q, overflow_d;

  logic                           consume;
  logic [BIN_BITS-1:0]            consume_addr;
  logic [COUNT_W:0]               sum;
  logic                           new_ovf;
  logic [COUNT_W-1:0]             new_cum;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    flush_cnt_d    = flush_cnt_q;
    clear_d        = clear_q;
    tgt_d          = tgt_q;
    vld_d          = vld_q;
    pipe_addr_d    = pipe_addr_q;
    cum_d          = cum_q;
    ovf_d          = ovf_q;
    found_d        = found_q;
    thr_d          = thr_q;
    max_d          = max_q;
    max_bin_d      = max_bin_q;
    thresh_d       = thresh_q;
    thresh_valid_d = thresh_valid_q;
    max_count_d    = max_count_q;
    max_bin_res_d  = max_bin_res_q;
    total_d        = total_q;
    overflow_d     = overflow_q;

    // Address/valid pipeline lines up each issued bin index with its returning read data.
    vld_d[0]       = (state_q == SCAN);
    pipe_addr_d[0] = addr_q;
    for (int i = 1; i < READ_LAT; i++) begin
      vld_d[i]       = vld_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end

    consume      = vld_q[READ_LAT-1];
    consume_addr = pipe_addr_q[READ_LAT-1];
    sum          = {1'b0, cum_q} + {1'b0, iSrcQ};
    new_ovf      = ovf_q | sum[COUNT_W];
    new_cum      = new_ovf ? '1 : sum[COUNT_W-1:0];

    cdf_we_d   = consume;
    cdf_addr_d = consume ? consume_addr : '0;
    cdf_data_d = consume ? new_cum : '0;

    if (consume) begin
      cum_d = new_cum;
      ovf_d = new_ovf;
      for (int p = 0; p < NUM_PCT; p++) begin
        if (!found_q[p] && (new_cum > tgt_q[p*COUNT_W +: COUNT_W])) begin
          found_d[p]                   = 1'b1;
          thr_d[p*BIN_BITS +: BIN_BITS] = consume_addr;
        end
      end
      if (iSrcQ > max_q) begin
        max_d     = iSrcQ;
        max_bin_d = consume_addr;
      end
    end

    case (state_q)
      IDLE: begin
        if (iStart) begin
          state_d   = SCAN;
          addr_d    = '0;
          clear_d   = iClearSrc;
          tgt_d     = iTargets;
          cum_d     = '0;
          ovf_d     = 1'b0;
          found_d   = '0;
          thr_d     = '0;
          max_d     = '0;
          max_bin_d = '0;
        end
      end
      SCAN: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == '1) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end
      end
      // Drains the read pipeline and the registered CDF write of the last bin.
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (flush_cnt_q == FLUSH_W'(READ_LAT)) begin
          state_d        = DONE;
          thresh_d       = thr_q;
          thresh_valid_d = found_q;
          max_count_d    = max_q;
          max_bin_res_d  = max_bin_q;
          total_d        = cum_q;
          overflow_d     = ovf_q;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      flush_cnt_q    <= '0;
      clear_q        <= 1'b0;
      tgt_q          <= '0;
      vld_q          <= '0;
      pipe_addr_q    <= '0;
      cum_q          <= '0;
      ovf_q          <= 1'b0;
      found_q        <= '0;
      thr_q          <= '0;
      max_q          <= '0;
      max_bin_q      <= '0;
      cdf_we_q       <= 1'b0;
      cdf_addr_q     <= '0;
      cdf_data_q     <= '0;
      thresh_q       <= '0;
      thresh_valid_q <= '0;
      max_count_q    <= '0;
      max_bin_res_q  <= '0;
      total_q        <= '0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      flush_cnt_q    <= flush_cnt_d;
      clear_q        <= clear_d;
      tgt_q          <= tgt_d;
      vld_q          <= vld_d;
      pipe_addr_q    <= pipe_addr_d;
      cum_q          <= cum_d;
      ovf_q          <= ovf_d;
      found_q        <= found_d;
      thr_q          <= thr_d;
      max_q          <= max_d;
      max_bin_q      <= max_bin_d;
      cdf_we_q       <= cdf_we_d;
      cdf_addr_q     <= cdf_addr_d;
      cdf_data_q     <= cdf_data_d;
      thresh_q       <= thresh_d;
      thresh_valid_q <= thresh_valid_d;
      max_count_q    <= max_count_d;
      max_bin_res_q  <= max_bin_res_d;
      total_q        <= total_d;
      overflow_q     <= overflow_d;
    end
  end

  // The source bin is zeroed in the same cycle its count is consumed.
  assign oSrcWe       = consume & clear_q;
  assign oSrcWAddr    = oSrcWe ? consume_addr : '0;
  assign oBusy        = (state_q == SCAN) || (state_q == FLUSH);
  assign oDone        = (state_q == DONE);
  assign oSrcAddr     = (state_q == SCAN) ? addr_q : '0;
  assign oCdfWe       = cdf_we_q;
  assign oCdfAddr     = cdf_addr_q;
  assign oCdfData     = cdf_data_q;
  assign oThresh      = thresh_q;
  assign oThreshValid = thresh_valid_q;
  assign oMaxCount    = max_count_q;
  assign oMaxBin      = max_bin_res_q;
  assign oTotal       = total_q;
  assign oOverflow    = overflow_q;

endmodule

// File: tb/tb_percentile_cdf_engine.sv
// Scoreboard bench: two engines (read latency 1 and 2) on modelled histogram RAMs.
module tb_percentile_cdf_engine;

  localparam int N = 256;
  localparam logic [19:0] SAT = 20'hFFFFF;

  typedef struct {
    logic [7:0]  addr;
    logic [19:0] data;
    int          cyc;
  } cdf_t;

  typedef struct {
    logic [23:0] thr;
    logic [2:0]  vld;
    logic [19:0] maxc;
    logic [7:0]  maxbin;
    logic [19:0] total;
    logic        ovf;
    int          cyc;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  start = '0;
  logic        clear_src = 1'b0;
  logic [59:0] targets = '0;
  logic [1:0]  busy, done, src_we, cdf_we, ovf;
  logic [7:0]  src_addr [2];
  logic [7:0]  src_waddr [2];
  logic [7:0]  cdf_addr [2];
  logic [19:0] cdf_data [2];
  logic [23:0] thresh [2];
  logic [2:0]  tvalid [2];
  logic [19:0] maxc [2];
  logic [7:0]  maxbin [2];
  logic [19:0] total [2];
  logic [19:0] rd1 [2];
  logic [19:0] rd2 [2];
  logic [19:0] mem [2][N];
  logic [1:0]  fill_req = '0;
  int          fill_kind = 0;

  int   checks = 0, errors = 0;
  int   cyc = 0, start_cyc = 0, act = 0;
  int   done_cnt = 0, srcw_cnt = 0;
  bit   mon_en = 0, chk_addr = 0;
  int   k_mon, lat_mon;
  cdf_t ce;
  res_t re;
  cdf_t cdf_q[$];
  res_t res_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  percentile_cdf_engine #(.BIN_BITS(8), .COUNT_W(20), .NUM_PCT(3), .READ_LAT(1)) u_dut_l1 (
    .iClk(clk), .iRst_n(rst_n), .iStart(start[0]), .iClearSrc(clear_src), .iTargets(targets),
    .oBusy(busy[0]), .oDone(done[0]), .oSrcAddr(src_addr[0]), .iSrcQ(rd1[0]),
    .oSrcWAddr(src_waddr[0]), .oSrcWe(src_we[0]), .oCdfAddr(cdf_addr[0]), .oCdfData(cdf_data[0]),
    .oCdfWe(cdf_we[0]), .oThresh(thresh[0]), .oThreshValid(tvalid[0]), .oMaxCount(maxc[0]),
    .oMaxBin(maxbin[0]), .oTotal(total[0]), .oOverflow(ovf[0]));

  percentile_cdf_engine #(.BIN_BITS(8), .COUNT_W(20), .NUM_PCT(3), .READ_LAT(2)) u_dut_l2 (
    .iClk(clk), .iRst_n(rst_n), .iStart(start[1]), .iClearSrc(clear_src), .iTargets(targets),
    .oBusy(busy[1]), .oDone(done[1]), .oSrcAddr(src_addr[1]), .iSrcQ(rd2[1]),
    .oSrcWAddr(src_waddr[1]), .oSrcWe(src_we[1]), .oCdfAddr(cdf_addr[1]), .oCdfData(cdf_data[1]),
    .oCdfWe(cdf_we[1]), .oThresh(thresh[1]), .oThreshValid(tvalid[1]), .oMaxCount(maxc[1]),
    .oMaxBin(maxbin[1]), .oTotal(total[1]), .oOverflow(ovf[1]));

  function automatic logic [19:0] hist(input int kind, input int b);
    case (kind)
      0:       return 20'd1500;
      1:       return (b == 37) ? 20'd384000 : 20'd0;
      3:       return 20'd5000;
      5:       return 20'((b * 37) % 101);
      default: return 20'd0;
    endcase
  endfunction

  // Histogram RAM models: registered read port(s) plus the clear write port.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      rd1[i] <= mem[i][src_addr[i]];
      rd2[i] <= rd1[i];
      if (fill_req[i]) begin
        for (int b = 0; b < N; b++) mem[i][b] <= hist(fill_kind, b);
      end else if (src_we[i]) begin
        mem[i][src_waddr[i]] <= '0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      $error("[TB] %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: cumulative sum with clamp, first bin above each target, strict-greater mode.
  task automatic pushModel(input int kind, input logic [59:0] tg, input int lat, input int off);
    longint cum = 0;
    res_t   r;
    logic [19:0] h;
    r.thr = '0; r.vld = '0; r.maxc = '0; r.maxbin = '0; r.ovf = 1'b0;
    for (int b = 0; b < N; b++) begin
      h = hist(kind, b);
      cum += h;
      if (cum > longint'(SAT)) begin
        cum = longint'(SAT);
        r.ovf = 1'b1;
      end
      cdf_q.push_back('{addr: 8'(b), data: 20'(cum), cyc: off + 2 + b + lat});
      for (int p = 0; p < 3; p++) begin
        if (!r.vld[p] && (cum > longint'(tg[p*20 +: 20]))) begin
          r.vld[p] = 1'b1;
          r.thr[p*8 +: 8] = 8'(b);
        end
      end
      if (h > r.maxc) begin
        r.maxc = h;
        r.maxbin = 8'(b);
      end
    end
    r.total = 20'(cum);
    r.cyc = off + N + 2 + lat;
    res_q.push_back(r);
  endtask

  task automatic waitDone(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("done_timeout", done_cnt >= target, 1);
  endtask

  task automatic fillMem(input int inst, input int kind);
    fill_kind = kind;
    fill_req[inst] = 1'b1;
    @(posedge clk); #1;
    fill_req = '0;
  endtask

  task automatic applyStimulus(input int inst, input int kind, input bit fill,
                               input logic [59:0] tg, input bit clr);
    int base;
    act = inst;
    if (fill) fillMem(inst, kind);
    targets = tg;
    clear_src = clr;
    pushModel(kind, tg, inst + 1, 0);
    srcw_cnt = 0;
    base = done_cnt;
    chk_addr = 1;
    start[inst] = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    start[inst] = 1'b0;
    mon_en = 1;
    waitDone(base + 1, 400);
    checkOutput("srcwe_count", srcw_cnt, clr ? N : 0);
    checkOutput("cdf_leftover", cdf_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: pops scoreboard entries as the active engine writes CDF data and pulses done.
  always @(negedge clk) begin
    if (mon_en) begin
      k_mon = cyc - start_cyc + 1;
      lat_mon = act + 1;
      if (chk_addr && k_mon >= 1 && k_mon <= N) checkOutput("src_addr", src_addr[act], k_mon - 1);
      if (chk_addr && k_mon >= 1 && k_mon <= N + 2 + lat_mon)
        checkOutput("busy", busy[act], k_mon <= N + 1 + lat_mon);
      if (cdf_we[act]) begin
        checkOutput("cdf_pending", cdf_q.size() != 0, 1);
        if (cdf_q.size() != 0) begin
          ce = cdf_q.pop_front();
          checkOutput("cdf_addr", cdf_addr[act], ce.addr);
          checkOutput("cdf_data", cdf_data[act], ce.data);
          checkOutput("cdf_cycle", k_mon, ce.cyc);
        end
      end
      if (src_we[act]) begin
        srcw_cnt++;
        checkOutput("srcw_addr", src_waddr[act], k_mon - 1 - lat_mon);
      end
      if (done[act]) begin
        done_cnt++;
        checkOutput("res_pending", res_q.size() != 0, 1);
        if (res_q.size() != 0) begin
          re = res_q.pop_front();
          checkOutput("done_cycle", k_mon, re.cyc);
          checkOutput("res_thresh", thresh[act], re.thr);
          checkOutput("res_valid", tvalid[act], re.vld);
          checkOutput("res_maxc", maxc[act], re.maxc);
          checkOutput("res_maxbin", maxbin[act], re.maxbin);
          checkOutput("res_total", total[act], re.total);
          checkOutput("res_ovf", ovf[act], re.ovf);
          checkOutput("busy_in_done", busy[act], 0);
        end
      end
    end
  end

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_we"}, {src_we, cdf_we}, 0);
    checkOutput({tag, "_addr"}, {src_addr[0], src_waddr[0], cdf_addr[0]}, 0);
    checkOutput({tag, "_cdf_data"}, cdf_data[0], 0);
    checkOutput({tag, "_thresh"}, {tvalid[0], thresh[0]}, 0);
    checkOutput({tag, "_max"}, {maxc[0], maxbin[0]}, 0);
    checkOutput({tag, "_total"}, {ovf[0], total[0]}, 0);
  endtask

  initial begin
    int seen;
    logic [59:0] tg_std, tg_ovf, tg_pat;
    tg_std = {20'd288000, 20'd192000, 20'd96000};
    tg_ovf = {20'd1048575, 20'd500000, 20'd1000000};
    tg_pat = {20'd20000, 20'd500, 20'd8000};

    #2;
    checkZeroOutputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] uniform histogram, latency 1");
    applyStimulus(0, 0, 1, tg_std, 0);
    checkOutput("uni_thresh", thresh[0], 24'hC08040);
    checkOutput("uni_valid", tvalid[0], 3'b111);
    checkOutput("uni_max", {maxc[0], maxbin[0]}, {20'd1500, 8'd0});
    checkOutput("uni_total", {ovf[0], total[0]}, {1'b0, 20'd384000});

    $display("[TB] single populated bin");
    applyStimulus(0, 1, 1, tg_std, 0);
    checkOutput("one_thresh", thresh[0], 24'h252525);
    checkOutput("one_maxbin", maxbin[0], 8'd37);

    $display("[TB] all-zero histogram");
    applyStimulus(0, 2, 1, tg_std, 0);
    checkOutput("zero_res", {tvalid[0], thresh[0], maxc[0], total[0]}, 0);

    $display("[TB] saturating histogram");
    applyStimulus(0, 3, 1, tg_ovf, 0);
    checkOutput("ovf_flag", ovf[0], 1'b1);
    checkOutput("ovf_total", total[0], SAT);
    checkOutput("ovf_thresh", thresh[0], {8'd0, 8'd100, 8'd200});
    checkOutput("ovf_valid", tvalid[0], 3'b011);

    $display("[TB] ramp pattern with ties and unordered targets");
    applyStimulus(0, 5, 1, tg_pat, 0);

    $display("[TB] clear mode, latency 2");
    applyStimulus(1, 5, 1, tg_pat, 1);
    applyStimulus(1, 2, 0, tg_std, 0);
    checkOutput("rescan_res", {tvalid[1], thresh[1], maxc[1], maxbin[1], total[1], ovf[1]}, 0);

    $display("[TB] start held high across two scans");
    act = 0;
    chk_addr = 0;
    fillMem(0, 0);
    targets = tg_std;
    clear_src = 1'b0;
    pushModel(0, tg_std, 1, 0);
    pushModel(0, tg_std, 1, N + 4);
    seen = done_cnt;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    repeat (N + 4) @(posedge clk);
    #1 start[0] = 1'b0;
    waitDone(seen + 2, 700);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("held_done_count", done_cnt, seen + 2);
    checkOutput("held_res_leftover", res_q.size(), 0);

    $display("[TB] reset in the middle of a scan");
    mon_en = 0;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (99) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkZeroOutputs("midrst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (done[0]) seen++;
    end
    checkOutput("midrst_no_done", seen, 0);
    checkOutput("midrst_idle", busy[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
